// File: rtl/shot_pkg.sv
// Shared types for the shot pool: coordinates, flight direction, slot state.
package shot_pkg;

  // Signed working coordinate, COORD_W+1 bits for the default COORD_W of 11.
  typedef logic signed [11:0] coord_t;
  typedef coord_t [1:0] xy_t;

  typedef enum logic [1:0] {
    STRAIGHT = 2'd0,
    LEFT     = 2'd1,
    RIGHT    = 2'd2
  } dir_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_t;

  // {left,right}: 10 -> LEFT, 01 -> RIGHT, 00/11 -> STRAIGHT
  function automatic dir_t decode_dir(input logic left, input logic right);
    case ({left, right})
      2'b10:   return LEFT;
      2'b01:   return RIGHT;
      default: return STRAIGHT;
    endcase
  endfunction

endpackage

// File: rtl/shot_pool_ctrl_slot.sv
// One shot slot: IDLE/FLYING state, coordinates, direction and damage bit.
module shot_slot
  import shot_pkg::*;
#(
  parameter int COORD_W   = 11,
  parameter int SPEED_Y   = 4,
  parameter int SPEED_X   = 2,
  parameter int SCREEN_W  = 640,
  parameter int SHOT_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [1:0][COORD_W-1:0] load_xy,
  input  dir_t                    load_dir,
  input  logic                    load_high_damage,
  input  logic                    tick,
  input  logic                    collision,
  output logic                    o_active,
  output logic [1:0][COORD_W-1:0] o_xy,
  output logic                    o_high_damage
);

  localparam logic signed [COORD_W:0] L_SPEED_X = (COORD_W+1)'(SPEED_X);
  localparam logic signed [COORD_W:0] L_SPEED_Y = (COORD_W+1)'(SPEED_Y);
  localparam logic signed [COORD_W:0] L_X_MAX   = (COORD_W+1)'(SCREEN_W - SHOT_SIZE);

  slot_state_t               r_state;
  slot_state_t               w_state_next;
  logic [1:0][COORD_W-1:0]   r_xy;
  dir_t                      r_dir;
  logic                      r_high_damage;
  logic signed [COORD_W:0]   w_cur_x;
  logic signed [COORD_W:0]   w_cur_y;
  logic signed [COORD_W:0]   w_new_x;
  logic signed [COORD_W:0]   w_new_y;
  logic                      w_out_of_bounds;
  logic                      w_move;

  // Candidate next position and screen-exit test, in signed arithmetic
  always_comb begin
    w_cur_x = $signed({1'b0, r_xy[0]});
    w_cur_y = $signed({1'b0, r_xy[1]});
    w_new_y = w_cur_y - L_SPEED_Y;
    case (r_dir)
      LEFT:    w_new_x = w_cur_x - L_SPEED_X;
      RIGHT:   w_new_x = w_cur_x + L_SPEED_X;
      default: w_new_x = w_cur_x;
    endcase
    w_out_of_bounds = w_new_y[COORD_W] | w_new_x[COORD_W] | (w_new_x > L_X_MAX);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: collision beats movement; leaving the screen retires the shot
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (load) w_state_next = FLYING;
      FLYING: if (collision || (tick && w_out_of_bounds)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs and move enable decoded from the registered state
  always_comb begin
    o_active      = (r_state == FLYING);
    o_xy          = r_xy;
    o_high_damage = r_high_damage;
    w_move        = (r_state == FLYING) && tick && !collision && !w_out_of_bounds;
  end

  // Coordinate/direction/damage registers; retired slots keep their last values
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xy          <= '0;
      r_dir         <= STRAIGHT;
      r_high_damage <= 1'b0;
    end else if (load && r_state == IDLE) begin
      r_xy          <= load_xy;
      r_dir         <= load_dir;
      r_high_damage <= load_high_damage;
    end else if (w_move) begin
      r_xy[0] <= w_new_x[COORD_W-1:0];
      r_xy[1] <= w_new_y[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/shot_pool_ctrl.sv
// Shot pool: lowest-free allocation, fire cooldown, fire_ack and live count.
module shot_pool_ctrl
  import shot_pkg::*;
#(
  parameter int NUM_SHOTS       = 8,
  parameter int COORD_W         = 11,
  parameter int SPEED_Y         = 4,
  parameter int SPEED_X         = 2,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int SPAWN_OFFSET_X  = 8,
  parameter int SCREEN_W        = 640,
  parameter int SHOT_SIZE       = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  startOfFrame,
  input  logic                                  fire_req,
  input  logic                                  left,
  input  logic                                  right,
  input  logic                                  high_damage,
  input  logic [1:0][COORD_W-1:0]               player_xy,
  input  logic [NUM_SHOTS-1:0]                  collision,
  output logic                                  fire_ack,
  output logic [NUM_SHOTS-1:0]                  shots_active,
  output logic [NUM_SHOTS-1:0][1:0][COORD_W-1:0] shots_xy,
  output logic [NUM_SHOTS-1:0]                  shots_high_damage,
  output logic [$clog2(NUM_SHOTS+1)-1:0]        active_count,
  output logic                                  pool_full
);

  localparam int CNT_W = $clog2(NUM_SHOTS + 1);
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0] L_COOLDOWN = CD_W'(COOLDOWN_FRAMES);

  logic [CD_W-1:0]         r_cooldown;
  logic                    r_fire_ack;
  logic [NUM_SHOTS-1:0]    w_active;
  logic [NUM_SHOTS-1:0]    w_free_onehot;
  logic [NUM_SHOTS-1:0]    w_load;
  logic                    w_any_free;
  logic                    w_accept;
  logic [1:0][COORD_W-1:0] w_spawn_xy;
  dir_t                    w_spawn_dir;
  logic [CNT_W-1:0]        w_count;

  // Lowest-index idle slot from the registered mask, and the accept decision
  always_comb begin
    w_free_onehot = '0;
    w_any_free    = 1'b0;
    for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
      if (!w_active[i] && !w_any_free) begin
        w_free_onehot[i] = 1'b1;
        w_any_free       = 1'b1;
      end
    end
    w_accept      = fire_req && !reset && (r_cooldown == '0) && w_any_free;
    w_load        = w_accept ? w_free_onehot : '0;
    w_spawn_xy[0] = player_xy[0] + COORD_W'(SPAWN_OFFSET_X);
    w_spawn_xy[1] = player_xy[1];
    w_spawn_dir   = decode_dir(left, right);
  end

  // Cooldown: reload on accept (wins over a coincident frame), else count frames down
  always_ff @(posedge clk) begin
    if (reset)                                  r_cooldown <= '0;
    else if (w_accept)                          r_cooldown <= L_COOLDOWN;
    else if (startOfFrame && r_cooldown != '0)  r_cooldown <= r_cooldown - CD_W'(1);
  end

  // One-cycle acknowledge aligned with the slot becoming live
  always_ff @(posedge clk) begin
    if (reset) r_fire_ack <= 1'b0;
    else       r_fire_ack <= w_accept;
  end

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    shot_slot #(
      .COORD_W   (COORD_W),
      .SPEED_Y   (SPEED_Y),
      .SPEED_X   (SPEED_X),
      .SCREEN_W  (SCREEN_W),
      .SHOT_SIZE (SHOT_SIZE)
    ) u_slot (
      .clk              (clk),
      .reset            (reset),
      .load             (w_load[g]),
      .load_xy          (w_spawn_xy),
      .load_dir         (w_spawn_dir),
      .load_high_damage (high_damage),
      .tick             (startOfFrame),
      .collision        (collision[g]),
      .o_active         (w_active[g]),
      .o_xy             (shots_xy[g]),
      .o_high_damage    (shots_high_damage[g])
    );
  end

  // Popcount of live slots
  always_comb begin
    w_count = '0;
    for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
      w_count = w_count + CNT_W'(w_active[i]);
    end
  end

  assign shots_active = w_active;
  assign fire_ack     = r_fire_ack;
  assign active_count = w_count;
  assign pool_full    = &w_active;

endmodule

// File: tb/tb_shot_pool_ctrl.sv
// Bench for shot_pool_ctrl: vector table for flight/retire cases, scoreboard for spawns.
module tb_shot_pool_ctrl;
  import shot_pkg::*;

  localparam int N  = 8;
  localparam int CW = 11;

  logic                   clk = 1'b0;
  logic                   reset, startOfFrame, fire_req, left, right, high_damage;
  logic [1:0][CW-1:0]     player_xy;
  logic [N-1:0]           collision;
  logic                   fire_ack;
  logic [N-1:0]           shots_active;
  logic [N-1:0][1:0][CW-1:0] shots_xy;
  logic [N-1:0]           shots_high_damage;
  logic [3:0]             active_count;
  logic                   pool_full;

  always #5 clk = ~clk;

  shot_pool_ctrl #(
    .NUM_SHOTS(N), .COORD_W(CW), .SPEED_Y(4), .SPEED_X(2), .COOLDOWN_FRAMES(6),
    .SPAWN_OFFSET_X(8), .SCREEN_W(640), .SHOT_SIZE(16)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .fire_req(fire_req),
    .left(left), .right(right), .high_damage(high_damage), .player_xy(player_xy),
    .collision(collision), .fire_ack(fire_ack), .shots_active(shots_active),
    .shots_xy(shots_xy), .shots_high_damage(shots_high_damage),
    .active_count(active_count), .pool_full(pool_full)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acks  = 0;

  typedef struct { int slot; int x; int y; bit hd; int due; } exp_t;
  exp_t sb[$];

  typedef struct { int px; int py; bit l; bit r; bit hd; int nfr; bit act; int ex; int ey; } vec_t;
  vec_t vt[10];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every fire_ack must match the oldest expected spawn
  always @(negedge clk) begin : mon
    exp_t e;
    if (fire_ack === 1'b1) begin
      n_acks++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_fire_ack: got fire_ack=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", cyc, e.due);
        check("ack_slot_active", shots_active[e.slot], 1);
        check("ack_x", shots_xy[e.slot][0], e.x);
        check("ack_y", shots_xy[e.slot][1], e.y);
        check("ack_hd", shots_high_damage[e.slot], e.hd);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_fire_ack: got fire_ack=0 at cycle %0d, required 1 for slot %0d", cyc, e.slot);
    end
  end

  task automatic push_exp(input int slot, input int x, input int y, input bit hd);
    exp_t e;
    e.slot = slot; e.x = x & 2047; e.y = y; e.hd = hd; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    startOfFrame = 0; fire_req = 0; left = 0; right = 0; high_damage = 0;
    collision = '0; player_xy = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst_active", shots_active, 0);
    check("rst_xy", (shots_xy != '0), 0);
    check("rst_hd", shots_high_damage, 0);
    check("rst_ack", fire_ack, 0);
    check("rst_count", active_count, 0);
    check("rst_full", pool_full, 0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1;
      @(negedge clk);
      startOfFrame = 0;
      @(negedge clk);
    end
  endtask

  task automatic fire(input int px, input int py, input bit l, input bit r, input bit hd,
                      input int slot, input bit with_sof);
    player_xy[0] = CW'(px);
    player_xy[1] = CW'(py);
    left = l; right = r; high_damage = hd;
    fire_req = 1;
    startOfFrame = with_sof;
    push_exp(slot, px + 8, py, hd);
    @(negedge clk);
    fire_req = 0;
    startOfFrame = 0;
    check("fire_ack_pulse", fire_ack, 1);
    @(negedge clk);
    check("fire_ack_low", fire_ack, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  mcd, mcnt, acks0;
    bit  sof, acc;

    vt[0] = '{100,  400, 0, 0, 0, 3, 1, 108, 388};
    vt[1] = '{100,  400, 1, 0, 0, 2, 1, 104, 392};
    vt[2] = '{606,  400, 0, 1, 0, 1, 1, 616, 396};
    vt[3] = '{615,  400, 0, 1, 0, 1, 0, 623, 400};
    vt[4] = '{100,  6,   0, 0, 0, 1, 1, 108, 2};
    vt[5] = '{100,  6,   0, 0, 0, 2, 0, 108, 2};
    vt[6] = '{2041, 400, 1, 0, 0, 1, 0, 1,   400};
    vt[7] = '{2042, 400, 1, 0, 0, 1, 1, 0,   396};
    vt[8] = '{100,  400, 1, 1, 1, 1, 1, 108, 396};
    vt[9] = '{606,  400, 0, 1, 0, 5, 1, 624, 380};

    idle_inputs();
    reset = 1;
    @(negedge clk);

    // Single-shot flight and retirement vectors, each from a fresh reset
    for (int i = 0; i < 10; i++) begin
      do_reset();
      fire(vt[i].px, vt[i].py, vt[i].l, vt[i].r, vt[i].hd, 0, 0);
      frames(vt[i].nfr);
      check($sformatf("vec%0d_active", i), shots_active[0], vt[i].act);
      check($sformatf("vec%0d_x", i), shots_xy[0][0], vt[i].ex);
      check($sformatf("vec%0d_y", i), shots_xy[0][1], vt[i].ey);
      check($sformatf("vec%0d_hd", i), shots_high_damage[0], vt[i].hd);
      check($sformatf("vec%0d_count", i), active_count, vt[i].act);
    end

    // Spawn in a startOfFrame cycle is not moved in that frame
    do_reset();
    fire(100, 400, 0, 0, 0, 0, 1);
    frames(1);
    check("sof_spawn_y", shots_xy[0][1], 396);

    // Held fire_req: one spawn per 6 frames until full, then nothing
    do_reset();
    mcd = 0; mcnt = 0; acks0 = n_acks;
    player_xy[0] = CW'(100); player_xy[1] = CW'(400);
    for (int c = 0; c < 260; c++) begin
      sof = ((c % 4) == 3);
      acc = (mcd == 0) && (mcnt < N);
      fire_req = 1;
      startOfFrame = sof;
      if (acc) begin
        push_exp(mcnt, 108, 400, 0);
        mcd = 6;
        mcnt++;
      end else if (sof && mcd > 0) begin
        mcd--;
      end
      @(negedge clk);
    end
    fire_req = 0; startOfFrame = 0;
    @(negedge clk);
    check("hold_acks", n_acks - acks0, 8);
    check("hold_full", pool_full, 1);
    check("hold_count", active_count, 8);
    check("hold_mask", shots_active, 8'hFF);

    // Collision freeing a slot in the accept cycle; freed slot reused next
    do_reset();
    fire(100, 400, 0, 0, 0, 0, 0); frames(6);
    fire(100, 400, 0, 0, 0, 1, 0); frames(6);
    fire(100, 400, 0, 0, 0, 2, 0); frames(6);
    player_xy[0] = CW'(200); player_xy[1] = CW'(300);
    fire_req = 1;
    collision = 8'b0010_0010;
    push_exp(3, 208, 300, 0);
    @(negedge clk);
    fire_req = 0; collision = '0;
    check("coll_mask", shots_active, 8'b0000_1101);
    check("coll_count", active_count, 3);
    frames(6);
    fire(50, 300, 0, 0, 1, 1, 0);
    check("reuse_mask", shots_active, 8'b0000_1111);
    // Cooldown blocks an immediate second request
    fire_req = 1;
    repeat (3) begin
      @(negedge clk);
      check("cooldown_block", fire_ack, 0);
    end
    fire_req = 0;
    @(negedge clk);

    // Collision and frame tick together: retire at pre-move coordinates
    do_reset();
    fire(100, 400, 0, 0, 0, 0, 0);
    collision = 8'b0000_0001;
    startOfFrame = 1;
    @(negedge clk);
    collision = '0; startOfFrame = 0;
    check("coll_sof_active", shots_active[0], 0);
    check("coll_sof_x", shots_xy[0][0], 108);
    check("coll_sof_y", shots_xy[0][1], 400);

    // Reset mid-flight with five live shots; fire in reset cycle dropped
    do_reset();
    for (int k = 0; k < 5; k++) begin
      fire(100, 400, 0, 0, 0, k, 0);
      frames(6);
    end
    check("five_count", active_count, 5);
    reset = 1;
    fire_req = 1;
    @(negedge clk);
    reset = 0;
    fire_req = 0;
    check("midrst_active", shots_active, 0);
    check("midrst_xy", (shots_xy != '0), 0);
    check("midrst_count", active_count, 0);
    check("midrst_ack", fire_ack, 0);
    @(negedge clk);
    check("midrst_dropped_fire", fire_ack, 0);
    check("midrst_still_idle", shots_active, 0);
    fire(100, 400, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
